// File: rtl/buf_pkg.sv
// Shared definitions for the SRAM buffer read path: FSM encoding and default widths.
package buf_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } state_e;

  localparam int unsigned ACT_DATA_WIDTH = 64;
  localparam int unsigned WGT_DATA_WIDTH = 256;
  localparam int unsigned BUF_ADDR_WIDTH = 8;
  localparam int unsigned BUF_LEN_WIDTH  = 9;
  localparam int unsigned BUF_FIFO_DEPTH = 4;

  // Bits needed to hold an occupancy count of 0..depth.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/buf_rd_streamer_if.sv
// Control, buffer read port and output stream of one buffer read streamer.
interface buf_rd_streamer_if
  import buf_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = BUF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = ACT_DATA_WIDTH,
  parameter int unsigned LEN_WIDTH  = BUF_LEN_WIDTH
) ();

  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [LEN_WIDTH-1:0]  len;
  logic [ADDR_WIDTH-1:0] stride;
  logic                  busy;
  logic                  done;
  logic                  buf_rd_en;
  logic [ADDR_WIDTH-1:0] buf_rd_addr;
  logic [DATA_WIDTH-1:0] buf_rd_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;

  // Streamer side.
  modport master (
    input  start, base_addr, len, stride, buf_rd_data, out_ready,
    output busy, done, buf_rd_en, buf_rd_addr, out_valid, out_data, out_last
  );

  // Controller, buffer and consumer side.
  modport slave (
    output start, base_addr, len, stride, buf_rd_data, out_ready,
    input  busy, done, buf_rd_en, buf_rd_addr, out_valid, out_data, out_last
  );

endinterface

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO: head word visible on rdata while not empty, with count output.
module sync_fifo
  import buf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = ACT_DATA_WIDTH,
  parameter int unsigned DEPTH      = BUF_FIFO_DEPTH,
  localparam int unsigned PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W     = cnt_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  empty,
  output logic [CNT_W-1:0]      count
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic                  do_push, do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q != CNT_W'(DEPTH)) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= next_ptr(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= next_ptr(rd_ptr_q);
      if (do_push && !do_pop)      count_q <= count_q + CNT_W'(1);
      else if (do_pop && !do_push) count_q <= count_q - CNT_W'(1);
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/buf_rd_streamer.sv
// Issues LEN strided reads to a 1-cycle-latency SRAM buffer and streams the words out via a
// prefetch FIFO sized so that in-flight reads always have a slot under backpressure.
module buf_rd_streamer
  import buf_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = BUF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = ACT_DATA_WIDTH,
  parameter int unsigned LEN_WIDTH  = BUF_LEN_WIDTH,
  parameter int unsigned FIFO_DEPTH = BUF_FIFO_DEPTH
) (
  input logic               clk,
  input logic               rst_n,
  buf_rd_streamer_if.master bus
);

  localparam int unsigned   CNT_W   = cnt_width(FIFO_DEPTH);
  localparam logic [CNT_W:0] DEPTH_V = (CNT_W + 1)'(FIFO_DEPTH);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, stride_q;
  logic [LEN_WIDTH-1:0]  len_q, issued_q, sent_q;
  logic                  pending_q;
  logic [CNT_W-1:0]      fifo_count;
  logic [CNT_W:0]        occupancy;
  logic                  fifo_empty;
  logic                  start_ok, rd_en, last_issue, pop, last_word;

  assign start_ok   = (state_q == StIdle) && bus.start;
  // Words held plus the read whose data is on buf_rd_data now; depends on registers only.
  assign occupancy  = {1'b0, fifo_count} + {{CNT_W{1'b0}}, pending_q};
  assign rd_en      = (state_q == StRun) && (issued_q < len_q) && (occupancy < DEPTH_V);
  assign last_issue = rd_en && (issued_q == len_q - LEN_WIDTH'(1));
  assign pop        = bus.out_valid && bus.out_ready;
  assign last_word  = (sent_q == len_q - LEN_WIDTH'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = (bus.len == '0) ? StDone : StRun;
      StRun:   if (last_issue) state_d = StDrain;
      StDrain: if (pop && last_word) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      stride_q  <= '0;
      len_q     <= '0;
      issued_q  <= '0;
      sent_q    <= '0;
      pending_q <= 1'b0;
    end else begin
      pending_q <= rd_en;
      if (start_ok) begin
        addr_q   <= bus.base_addr;
        stride_q <= bus.stride;
        len_q    <= bus.len;
        issued_q <= '0;
        sent_q   <= '0;
      end else begin
        if (rd_en) begin
          addr_q   <= addr_q + stride_q;
          issued_q <= issued_q + LEN_WIDTH'(1);
        end
        if (pop) sent_q <= sent_q + LEN_WIDTH'(1);
      end
    end
  end

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (pending_q),
    .wdata (bus.buf_rd_data),
    .pop   (pop),
    .rdata (bus.out_data),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bus.busy        = (state_q != StIdle);
  assign bus.done        = (state_q == StDone);
  assign bus.buf_rd_en   = rd_en;
  assign bus.buf_rd_addr = addr_q;
  assign bus.out_valid   = !fifo_empty;
  assign bus.out_last    = bus.out_valid && last_word;

endmodule

// File: tb/tb_buf_rd_streamer.sv
// Self-checking bench for buf_rd_streamer against a buffer model holding mem[i] = i.
module tb_buf_rd_streamer;
  import buf_pkg::*;

  localparam int unsigned AW = BUF_ADDR_WIDTH;
  localparam int unsigned DW = ACT_DATA_WIDTH;
  localparam int unsigned LW = BUF_LEN_WIDTH;
  localparam int unsigned FD = BUF_FIFO_DEPTH;

  typedef struct {
    int base;
    int len;
    int stride;
    int exp_last;
    int exp_done;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  buf_rd_streamer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

  buf_rd_streamer #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .LEN_WIDTH  (LW),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Buffer: 1-cycle read of mem[i] = i; junk on the data bus when no read was issued.
  always @(posedge clk)
    bus.buf_rd_data <= bus.buf_rd_en ? DW'(bus.buf_rd_addr) : {$urandom, $urandom};

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // mode 0: ready always high (exact timing checked); 1: random ready; 2: ready low cycles 5-10.
  task automatic run_xfer(input string tag, input int base, input int len, input int stride,
                          input int mode, input bit poke, output int done_cyc,
                          output longint last_data);
    int nreads = 0, npops = 0, occ = 0, ndone = 0, nbusy = 0, last_cyc = -1, exp = 0;
    int addr_err = 0, data_err = 0, last_err = 0, stab_err = 0, occ_err = 0, tim_err = 0;
    int budget = 4 * len + 40;
    bit held = 1'b0, finished = 1'b0, rdy = 1'b1;
    logic [DW-1:0] held_data = '0;
    logic held_last = 1'b0;
    done_cyc  = -1;
    last_data = -1;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.base_addr = AW'(base);
    bus.len       = LW'(len);
    bus.stride    = AW'(stride);
    bus.out_ready = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= budget && !finished; cyc++) begin
      @(negedge clk);
      bus.start = poke && (cyc == 3);
      if (poke && cyc == 3) begin
        bus.base_addr = 8'h55;
        bus.len       = LW'(7);
        bus.stride    = 8'h03;
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ($urandom_range(0, 3) != 0);
        default: rdy = !(cyc >= 5 && cyc < 11);
      endcase
      bus.out_ready = rdy;
      #1;
      occ = nreads - npops;
      if (occ > int'(FD) || (bus.buf_rd_en && occ >= int'(FD))) occ_err++;
      if (bus.buf_rd_en) begin
        exp = (base + nreads * stride) % 256;
        if (int'(bus.buf_rd_addr) != exp) addr_err++;
        if (mode == 0 && cyc != 1 + nreads) tim_err++;
        nreads++;
      end
      if (held && (!bus.out_valid || bus.out_data != held_data || bus.out_last != held_last))
        stab_err++;
      if (bus.out_valid && rdy) begin
        exp = (base + npops * stride) % 256;
        if (bus.out_data != DW'(exp)) data_err++;
        if (bus.out_last != (npops == len - 1)) last_err++;
        if (mode == 0 && cyc != 3 + npops) tim_err++;
        if (bus.out_last) begin
          last_cyc  = cyc;
          last_data = longint'(bus.out_data);
        end
        npops++;
      end
      held      = bus.out_valid && !rdy;
      held_data = bus.out_data;
      held_last = bus.out_last;
      if (bus.busy) nbusy++;
      if (bus.done) ndone++;
      if (done_cyc >= 0 && cyc == done_cyc + 1) finished = 1'b1;
      if (bus.done && done_cyc < 0) done_cyc = cyc;
    end
    bus.out_ready = 1'b1;
    if (!finished) check({tag, " timeout"}, 0, 1);
    check({tag, " reads"}, nreads, len);
    check({tag, " words"}, npops, len);
    check({tag, " addr errs"}, addr_err, 0);
    check({tag, " data errs"}, data_err, 0);
    check({tag, " last errs"}, last_err, 0);
    check({tag, " stable errs"}, stab_err, 0);
    check({tag, " occupancy errs"}, occ_err, 0);
    check({tag, " timing errs"}, tim_err, 0);
    check({tag, " done pulses"}, ndone, 1);
    check({tag, " done after last"}, done_cyc, (len == 0) ? 1 : last_cyc + 1);
    check({tag, " busy cycles"}, nbusy, done_cyc);
  endtask

  initial begin
    vec_t   vecs [6];
    int     dc;
    longint ld;
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.len       = '0;
    bus.stride    = '0;
    bus.out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #10;
    check("reset ctl", {bus.busy, bus.done, bus.buf_rd_en, bus.out_valid, bus.out_last}, 0);
    check("reset addr", bus.buf_rd_addr, 0);
    check("reset data", bus.out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;

    vecs[0] = '{base: 'h10, len: 4, stride: 1, exp_last: 'h13, exp_done: 7};
    vecs[1] = '{base: 'hFE, len: 4, stride: 1, exp_last: 'h01, exp_done: 7};
    vecs[2] = '{base: 'hF8, len: 3, stride: 4, exp_last: 'h00, exp_done: 6};
    vecs[3] = '{base: 'h00, len: 0, stride: 1, exp_last: 0,     exp_done: 1};
    vecs[4] = '{base: 'h80, len: 1, stride: 0, exp_last: 'h80, exp_done: 4};
    vecs[5] = '{base: 'h33, len: 5, stride: 0, exp_last: 'h33, exp_done: 8};
    for (int i = 0; i < 6; i++) begin
      run_xfer($sformatf("vec%0d", i), vecs[i].base, vecs[i].len, vecs[i].stride, 0, 1'b0,
               dc, ld);
      check($sformatf("vec%0d done cycle", i), dc, vecs[i].exp_done);
      if (vecs[i].len != 0) check($sformatf("vec%0d last word", i), ld, vecs[i].exp_last);
    end

    run_xfer("backpressure", 'h30, 16, 1, 2, 1'b0, dc, ld);
    check("backpressure last word", ld, 'h3F);

    run_xfer("start in run", 'h60, 12, 2, 0, 1'b1, dc, ld);
    check("start in run done cycle", dc, 15);
    check("start in run last word", ld, 'h76);

    for (int t = 0; t < 10; t++)
      run_xfer($sformatf("rand%0d", t), int'($urandom_range(0, 255)),
               int'($urandom_range(0, 24)), int'($urandom_range(0, 255)), 1, 1'b0, dc, ld);

    // Abort a transfer after three words have been handshaken.
    @(negedge clk);
    bus.start     = 1'b1;
    bus.base_addr = 8'h40;
    bus.len       = LW'(10);
    bus.stride    = 8'h01;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    check("abort busy before reset", bus.busy, 1);
    #1 rst_n = 1'b0;
    #1;
    check("abort ctl", {bus.busy, bus.done, bus.buf_rd_en, bus.out_valid, bus.out_last}, 0);
    check("abort addr", bus.buf_rd_addr, 0);
    check("abort data", bus.out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_xfer("post reset", 'h20, 2, 1, 0, 1'b0, dc, ld);
    check("post reset done cycle", dc, 5);
    check("post reset last word", ld, 'h21);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
